mem_master_ctrl: RTL and testbench
==================================

Name: mem_master_ctrl

Overview:
- Initiator-side controller that drives the calculator's word-addressed Memory block.
- Accepts single read/write requests from the calculator datapath over a Req/Ack handshake.
- Sequences the Memory's Valid/R_W/Addr/Din pins and absorbs the one-cycle registered read latency.
- Captures read data before the Memory returns Dout to high-Z.

Parameters:
WIDTH, 8, address width; Memory depth is 2^WIDTH words
DinLENGTH, 32, data word width

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Req  in  1  request strobe from datapath; sampled only in IDLE
Op  in  1  1 = write, 0 = read (same encoding as Memory R_W)
ReqAddr  in  WIDTH  target word address
WrData  in  DinLENGTH  write data
Ack  out  1  one-cycle completion pulse
RdData  out  DinLENGTH  last read result; held until the next read completes
Busy  out  1  high whenever state != IDLE
Err  out  1  read-back mismatch pulse, coincident with Ack (optional feature only)
MemValid  out  1  to Memory Valid
MemR_W  out  1  to Memory R_W
MemAddr  out  WIDTH  to Memory Addr
MemDin  out  DinLENGTH  to Memory Din
MemDout  in  DinLENGTH  from Memory Dout; may be high-Z

Behaviour:
- Reset low (asynchronous):
  - State = IDLE.
  - Ack, Busy, Err, MemValid, MemR_W = 0.
  - MemAddr, MemDin, RdData = 0.
  - Takes effect mid-transaction; the in-flight request is dropped with no Ack.
- Memory's own reset is active-high; the inversion is done at top level and is out of scope here.
- States: IDLE, ISSUE, CAPTURE, DONE (plus VFY_ISSUE, VFY_CAPTURE with the option).
- IDLE:
  - If Req=1 at an edge, latch Op, ReqAddr and WrData into internal registers, then go to ISSUE.
  - Datapath may change its inputs after the accepting edge.
- ISSUE: MemValid=1, MemR_W=latched Op, MemAddr/MemDin from latched values, for exactly one cycle.
  - Write: next state DONE.
  - Read: next state CAPTURE.
- CAPTURE:
  - MemValid=0.
  - At the exiting edge, RdData <= MemDout; this samples the word the Memory registered at the ISSUE edge.
  - Next state DONE.
- DONE: Ack=1 for one cycle, MemValid=0, then IDLE.
- Latency, counted from the accepting edge to the Ack cycle:
  - Write: Ack in the 2nd cycle.
  - Read: Ack in the 3rd cycle.
- Req is ignored while Busy. A Req still high in IDLE after Ack starts a new transaction; back-to-back transactions are legal with one IDLE cycle between them.
- MemValid is never high for two consecutive cycles. MemR_W and MemAddr are held stable whenever MemValid=1.
- Outside ISSUE states, MemAddr and MemDin hold their last values; MemR_W = 0.
- RdData is never updated by writes. It is never sampled outside CAPTURE, so high-Z on MemDout is never captured.
- Address wrap: none is needed. Addresses 0 and 2^WIDTH-1 are both legal and passed through unmodified.

Optional Feature:
- Macro: MEM_READBACK_CHECK_EN.
- Defined:
  - A write goes ISSUE -> VFY_ISSUE -> VFY_CAPTURE -> DONE.
  - VFY_ISSUE issues a read (MemValid=1, MemR_W=0) to the same address.
  - VFY_CAPTURE compares MemDout against the latched WrData; on mismatch, Err=1 together with Ack in DONE.
  - Write latency becomes 4 cycles; RdData is not updated by the check.
- Undefined: Err is tied 0, and the VFY states are not compiled.

Decomposition:
- Package mem_ctrl_pkg:
  - State enum.
  - OP_READ=1'b0 and OP_WRITE=1'b1 constants.
  - Default WIDTH/DinLENGTH localparams shared with Memory.
- No sub-module; a single FSM plus request and data registers.

Test Plan:
- Reset low for 3 cycles, then release -> all outputs 0, Busy=0. No MemValid pulse until the first Req.
- Write Op=1, ReqAddr=8'h05, WrData=32'hDEADBEEF -> MemValid=1/MemR_W=1/MemAddr=05 for one cycle, then Ack in the following cycle, Busy=1 for 2 cycles.
- Read ReqAddr=8'h05 after the write above -> Ack in the 3rd cycle, RdData=32'hDEADBEEF, RdData held after MemDout goes Z.
- Back-to-back with Req held high: write 8'hFF=32'h1, then read 8'h00 (reset value 0) -> two Acks, RdData=0, MemValid never high 2 cycles in a row.
- Reset low during CAPTURE of a read to 8'h05 -> immediate IDLE, no Ack, RdData=0; a new read afterwards completes normally.
- With MEM_READBACK_CHECK_EN, write 8'h10=32'hA5A5A5A5 with bench-forced MemDout corruption in VFY_CAPTURE -> Ack with Err=1. Without forcing -> Err=0 and 4-cycle latency.

Source files
------------

// File: rtl/mem_master_ctrl_pkg.sv
// Shared types and constants for the memory master controller and the Memory block.
// Optional macro MEM_READBACK_CHECK_EN adds the write read-back verify states.
package mem_ctrl_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DinLENGTH = 32;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE
`ifdef MEM_READBACK_CHECK_EN
        ,
        VFY_ISSUE,
        VFY_CAPTURE
`endif
    } state_t;

endpackage

// File: rtl/mem_master_ctrl_if.sv
// Request-side handshake plus Memory pin bundle for mem_master_ctrl.
// The master modport is the controller's view; slave is the datapath/Memory side.
interface mem_master_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DinLENGTH = DEF_DinLENGTH
);

    logic                 Req;
    logic                 Op;
    logic [WIDTH-1:0]     ReqAddr;
    logic [DinLENGTH-1:0] WrData;
    logic                 Ack;
    logic [DinLENGTH-1:0] RdData;
    logic                 Busy;
    logic                 Err;
    logic                 MemValid;
    logic                 MemR_W;
    logic [WIDTH-1:0]     MemAddr;
    logic [DinLENGTH-1:0] MemDin;
    logic [DinLENGTH-1:0] MemDout;

    modport master (
        input  Req, Op, ReqAddr, WrData, MemDout,
        output Ack, RdData, Busy, Err, MemValid, MemR_W, MemAddr, MemDin
    );

    modport slave (
        output Req, Op, ReqAddr, WrData, MemDout,
        input  Ack, RdData, Busy, Err, MemValid, MemR_W, MemAddr, MemDin
    );

endinterface

// File: rtl/mem_master_ctrl.sv
// Single-request initiator for the word-addressed Memory: issue, absorb read latency, ack.
// Optional macro MEM_READBACK_CHECK_EN re-reads every write and flags mismatches on Err.
module mem_master_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DinLENGTH = DEF_DinLENGTH
) (
    input  logic              Clk,
    input  logic              Reset,
    mem_master_ctrl_if.master bus
);

    state_t               state;
    state_t               state_nxt;
    logic                 op_q;
    logic [WIDTH-1:0]     addr_q;
    logic [DinLENGTH-1:0] din_q;
    logic [DinLENGTH-1:0] rd_q;

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The request latch doubles as the Memory address/data drivers, so they hold between requests
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            op_q   <= OP_READ;
            addr_q <= '0;
            din_q  <= '0;
            rd_q   <= '0;
        end else begin
            if (state == IDLE && bus.Req) begin
                op_q   <= bus.Op;
                addr_q <= bus.ReqAddr;
                din_q  <= bus.WrData;
            end
            if (state == CAPTURE) begin
                rd_q <= bus.MemDout;
            end
        end
    end

`ifdef MEM_READBACK_CHECK_EN
    logic err_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            err_q <= 1'b0;
        end else if (state == VFY_CAPTURE) begin
            err_q <= (bus.MemDout != din_q);
        end else if (state == IDLE) begin
            err_q <= 1'b0;
        end
    end
`endif

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (bus.Req) state_nxt = ISSUE;
            ISSUE: begin
                if (op_q == OP_WRITE) begin
`ifdef MEM_READBACK_CHECK_EN
                    state_nxt = VFY_ISSUE;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE:     state_nxt = DONE;
`ifdef MEM_READBACK_CHECK_EN
            VFY_ISSUE:   state_nxt = VFY_CAPTURE;
            VFY_CAPTURE: state_nxt = DONE;
`endif
            DONE:        state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        bus.MemValid = 1'b0;
        bus.MemR_W   = 1'b0;
        bus.Ack      = 1'b0;
        bus.Err      = 1'b0;
        bus.Busy     = (state != IDLE);
        case (state)
            ISSUE: begin
                bus.MemValid = 1'b1;
                bus.MemR_W   = op_q;
            end
`ifdef MEM_READBACK_CHECK_EN
            VFY_ISSUE: begin
                bus.MemValid = 1'b1;
                bus.MemR_W   = OP_READ;
            end
`endif
            DONE: begin
                bus.Ack = 1'b1;
`ifdef MEM_READBACK_CHECK_EN
                bus.Err = err_q;
`endif
            end
            default: begin
                bus.MemValid = 1'b0;
            end
        endcase
    end

    assign bus.MemAddr = addr_q;
    assign bus.MemDin  = din_q;
    assign bus.RdData  = rd_q;

endmodule

// File: tb/tb_mem_master_ctrl.sv
// Directed bench for mem_master_ctrl with a behavioural Memory and an Ack-driven scoreboard.
// Build with MEM_READBACK_CHECK_EN defined to exercise the read-back verify path.
module tb_mem_master_ctrl;

`ifdef MEM_READBACK_CHECK_EN
    localparam int WL = 4;
`else
    localparam int WL = 2;
`endif
    localparam int RL = 3;
    localparam logic [31:0] FLOAT_PAT = 32'hBAD0_0BAD;

    typedef struct packed {
        logic        is_read;
        logic [31:0] rdata;
        logic        err;
    } sb_t;

    logic Clk;
    logic Reset;

    mem_master_ctrl_if bus ();

    mem_master_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int   checks = 0;
    int   errors = 0;
    int   ack_cnt = 0;
    sb_t  sb[$];
    logic prev_v = 1'b0;
    logic corrupt = 1'b0;

    // Behavioural Memory: write or registered read on a Valid edge; Dout driven only the cycle after a read.
    // A floating bus is modelled as a junk pattern so any stray capture shows up.
    logic [31:0] mem [256];
    logic [31:0] dout_q = '0;
    logic        dout_en = 1'b0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
    end

    always @(posedge Clk) begin
        if (bus.MemValid && bus.MemR_W) mem[bus.MemAddr] <= bus.MemDin;
        if (bus.MemValid && !bus.MemR_W) dout_q <= mem[bus.MemAddr];
        dout_en <= bus.MemValid && !bus.MemR_W;
    end

    assign bus.MemDout = dout_en ? (dout_q ^ (corrupt ? 32'hFFFF_0000 : 32'h0)) : FLOAT_PAT;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on every Ack, plus the MemValid single-pulse rule
    always @(negedge Clk) begin
        if (prev_v) chk("memvalid_single", {31'b0, bus.MemValid}, 32'd0);
        prev_v <= bus.MemValid;
        if (bus.Ack) begin
            chk("ack_expected", {31'b0, (sb.size() != 0)}, 32'd1);
            if (sb.size() != 0) begin
                sb_t e;
                e = sb.pop_front();
                if (e.is_read) chk("rddata", bus.RdData, e.rdata);
                chk("err", {31'b0, bus.Err}, {31'b0, e.err});
            end
            ack_cnt <= ack_cnt + 1;
        end
    end

    task automatic txn(input logic op, input logic [7:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat);
        sb_t e;
        int  cyc;
        e.is_read = (op == 1'b0);
        e.rdata   = exp_rd;
        e.err     = exp_err;
        sb.push_back(e);
        bus.Req = 1'b1; bus.Op = op; bus.ReqAddr = addr; bus.WrData = wd;
        @(posedge Clk); #1;
        bus.Req = 1'b0; bus.Op = ~op; bus.ReqAddr = ~addr; bus.WrData = ~wd;
        chk("issue_valid", {31'b0, bus.MemValid}, 32'd1);
        chk("issue_rw", {31'b0, bus.MemR_W}, {31'b0, op});
        chk("issue_addr", {24'b0, bus.MemAddr}, {24'b0, addr});
        chk("issue_busy", {31'b0, bus.Busy}, 32'd1);
        if (op) chk("issue_din", bus.MemDin, wd);
        cyc = 1;
        while (!bus.Ack && cyc < 12) begin
            @(posedge Clk); #1;
            cyc++;
        end
        chk("ack_latency", cyc, lat);
        @(posedge Clk); #1;
        chk("idle_busy", {31'b0, bus.Busy}, 32'd0);
        chk("ack_one_cycle", {31'b0, bus.Ack}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        Reset = 1'b0;
        bus.Req = 1'b0; bus.Op = 1'b0; bus.ReqAddr = '0; bus.WrData = '0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_valid", {31'b0, bus.MemValid}, 32'd0);
        chk("rst_rw", {31'b0, bus.MemR_W}, 32'd0);
        chk("rst_busy", {31'b0, bus.Busy}, 32'd0);
        chk("rst_ack", {31'b0, bus.Ack}, 32'd0);
        chk("rst_err", {31'b0, bus.Err}, 32'd0);
        chk("rst_addr", {24'b0, bus.MemAddr}, 32'd0);
        chk("rst_din", bus.MemDin, 32'd0);
        chk("rst_rddata", bus.RdData, 32'd0);
        Reset = 1'b1;
        repeat (3) begin
            @(posedge Clk); #1;
            chk("idle_valid", {31'b0, bus.MemValid}, 32'd0);
            chk("idle_busy0", {31'b0, bus.Busy}, 32'd0);
        end

        txn(1'b1, 8'h05, 32'hDEADBEEF, 32'h0, 1'b0, WL);
        txn(1'b0, 8'h05, 32'h0, 32'hDEADBEEF, 1'b0, RL);
        repeat (3) @(posedge Clk);
        #1;
        chk("rddata_held", bus.RdData, 32'hDEADBEEF);

`ifdef MEM_READBACK_CHECK_EN
        corrupt = 1'b1;
        txn(1'b1, 8'h10, 32'hA5A5A5A5, 32'h0, 1'b1, 4);
        corrupt = 1'b0;
        chk("vfy_no_rddata", bus.RdData, 32'hDEADBEEF);
        txn(1'b1, 8'h10, 32'hA5A5A5A5, 32'h0, 1'b0, 4);
`endif

        // Back-to-back with Req held high across the write's Ack
        base = ack_cnt;
        sb.push_back('{is_read: 1'b0, rdata: 32'h0, err: 1'b0});
        sb.push_back('{is_read: 1'b1, rdata: 32'h0, err: 1'b0});
        bus.Req = 1'b1; bus.Op = 1'b1; bus.ReqAddr = 8'hFF; bus.WrData = 32'h1;
        @(posedge Clk); #1;
        bus.Op = 1'b0; bus.ReqAddr = 8'h00; bus.WrData = 32'h0;
        repeat (WL + 1) @(posedge Clk);
        #1;
        bus.Req = 1'b0;
        chk("b2b_second_issue", {31'b0, bus.MemValid}, 32'd1);
        t = 0;
        while (ack_cnt < base + 2 && t < 20) begin
            @(posedge Clk); #1;
            t++;
        end
        chk("b2b_acks", ack_cnt - base, 32'd2);
        chk("b2b_rddata", bus.RdData, 32'h0);
        chk("b2b_written", mem[8'hFF], 32'h1);

        txn(1'b0, 8'h05, 32'h0, 32'hDEADBEEF, 1'b0, RL);

        // Reset in the CAPTURE cycle of a read: no Ack, everything back to zero
        bus.Req = 1'b1; bus.Op = 1'b0; bus.ReqAddr = 8'h05;
        @(posedge Clk); #1;
        bus.Req = 1'b0;
        @(posedge Clk); #1;
        chk("pre_rst_capture_busy", {31'b0, bus.Busy}, 32'd1);
        Reset = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, bus.Busy}, 32'd0);
        chk("midrst_ack", {31'b0, bus.Ack}, 32'd0);
        chk("midrst_rddata", bus.RdData, 32'h0);
        chk("midrst_addr", {24'b0, bus.MemAddr}, 32'd0);
        base = ack_cnt;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("midrst_no_ack", ack_cnt - base, 32'd0);
        chk("midrst_rddata_after", bus.RdData, 32'h0);
        txn(1'b0, 8'h05, 32'h0, 32'hDEADBEEF, 1'b0, RL);
        chk("sb_drained", sb.size(), 32'd0);

        repeat (2) @(posedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
